stdp_weight_update: RTL and testbench

Pair-based STDP learning stage that sits directly downstream of the presynaptic and postsynaptic `lif` neurons in the `tt_um_stdp` top level. It consumes their spike outputs and measures the pre/post spike interval with saturating counters. It applies a binned potentiation/depression step to a saturating synaptic weight. It also drives a weighted current pulse back toward the postsynaptic neuron.

---
 rtl/stdp_pkg.sv | 17 +
 rtl/stdp_weight_update_spike_trace.sv | 32 +++
 rtl/stdp_weight_update.sv | 55 +++++
 tb/tb_stdp_weight_update.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// stdp_pkg: shared constants and the interval-to-delta binning used by the STDP stage.
package stdp_pkg;
    localparam int unsigned T_MAX = 15;
    localparam int unsigned BIN_1 = 3;
    localparam int unsigned BIN_2 = 7;
    localparam int unsigned BIN_3 = 11;
    localparam int unsigned BIN_4 = 14;
    localparam logic [4:0] D_1 = 5'd16;
    localparam logic [4:0] D_2 = 5'd8;
    localparam logic [4:0] D_3 = 5'd4;
    localparam logic [4:0] D_4 = 5'd2;

    // Intervals beyond the last bin never pair, so they map to no change.
    function automatic logic [4:0] stdp_delta(input int unsigned dt);
        return dt <= BIN_1 ? D_1 : dt <= BIN_2 ? D_2 : dt <= BIN_3 ? D_3 : dt <= BIN_4 ? D_4 : 5'd0;
    endfunction
endpackage

// File: rtl/stdp_weight_update_spike_trace.sv
// spike_trace: rising-edge spike detect plus a saturating interval counter and valid flag.
module spike_trace #(
    parameter int T_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spike,
    input  logic               clr,
    output logic               rise,
    output logic [T_WIDTH-1:0] cnt,
    output logic               valid
);
    localparam logic [T_WIDTH-1:0] CNT_MAX = '1;
    logic               spike_d;
    logic [T_WIDTH-1:0] cnt_nxt;

    assign rise    = spike & ~spike_d;
    assign cnt_nxt = cnt == CNT_MAX ? cnt : cnt + 1'b1;

    // Own event wins over a partner's clear, so simultaneous spikes both restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_d <= 1'b0;
            cnt     <= CNT_MAX;
            valid   <= 1'b0;
        end else begin
            spike_d <= spike;
            cnt     <= rise ? T_WIDTH'(1) : cnt_nxt;
            valid   <= rise | (valid & ~clr & (cnt_nxt != CNT_MAX));
        end
    end
endmodule

// File: rtl/stdp_weight_update.sv
// stdp_weight_update: pair-based STDP weight update with a weighted current pulse on pre spikes.
module stdp_weight_update
    import stdp_pkg::*;
#(
    parameter int W_WIDTH = 8,
    parameter int T_WIDTH = 4,
    parameter int W_INIT  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pre_spike,
    input  logic               post_spike,
    input  logic               learn_en,
    output logic [W_WIDTH-1:0] weight,
    output logic               update_w_flag,
    output logic [T_WIDTH-1:0] time_diff,
    output logic [W_WIDTH-1:0] syn_current
);
    logic               pre_rise, post_rise, pre_valid, post_valid, ltp, ltd;
    logic [T_WIDTH-1:0] pre_cnt, post_cnt;
    logic [W_WIDTH:0]   delta, sum, diff;

    spike_trace #(.T_WIDTH(T_WIDTH)) u_pre (
        .clk(clk), .rst_n(rst_n), .spike(pre_spike), .clr(ltp),
        .rise(pre_rise), .cnt(pre_cnt), .valid(pre_valid)
    );

    spike_trace #(.T_WIDTH(T_WIDTH)) u_post (
        .clk(clk), .rst_n(rst_n), .spike(post_spike), .clr(ltd),
        .rise(post_rise), .cnt(post_cnt), .valid(post_valid)
    );

    assign ltp   = post_rise & ~pre_rise & pre_valid;
    assign ltd   = pre_rise & ~post_rise & post_valid;
    assign delta = (W_WIDTH+1)'(stdp_delta(32'(ltp ? pre_cnt : post_cnt)));
    assign sum   = {1'b0, weight} + delta;
    assign diff  = {1'b0, weight} - delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight        <= W_WIDTH'(W_INIT);
            update_w_flag <= 1'b0;
            time_diff     <= '0;
            syn_current   <= '0;
        end else begin
            if (learn_en && ltp)
                weight <= sum[W_WIDTH] ? '1 : sum[W_WIDTH-1:0];
            else if (learn_en && ltd)
                weight <= diff[W_WIDTH] ? '0 : diff[W_WIDTH-1:0];
            update_w_flag <= ltp | ltd;
            time_diff     <= ltp ? pre_cnt : ltd ? post_cnt : time_diff;
            syn_current   <= pre_rise ? weight : '0;
        end
    end
endmodule

// File: tb/tb_stdp_weight_update.sv
// tb_stdp_weight_update: directed STDP scenarios with hand-computed weights and intervals.
module tb_stdp_weight_update;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pre_spike = 1'b0;
    logic       post_spike = 1'b0;
    logic       learn_en = 1'b1;
    logic [7:0] weight;
    logic       update_w_flag;
    logic [3:0] time_diff;
    logic [7:0] syn_current;
    int         checks = 0;
    int         errors = 0;

    stdp_weight_update #(.W_WIDTH(8), .T_WIDTH(4), .W_INIT(64)) dut (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
        .learn_en(learn_en), .weight(weight), .update_w_flag(update_w_flag),
        .time_diff(time_diff), .syn_current(syn_current)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic check_pair(input string tag, input int w, input int f, input int td);
        check({tag, "_w"}, 32'(weight), 32'(w));
        check({tag, "_flag"}, 32'(update_w_flag), 32'(f));
        if (f != 0) check({tag, "_td"}, 32'(time_diff), 32'(td));
    endtask

    task automatic ltp_pair(input int gap);
        drive(1'b1, 1'b0);
        idle(gap - 1);
        drive(1'b0, 1'b1);
    endtask

    task automatic ltd_pair(input int gap);
        drive(1'b0, 1'b1);
        idle(gap - 1);
        drive(1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_w", 32'(weight), 32'd64);
        check("rst_flag", 32'(update_w_flag), 32'd0);
        check("rst_td", 32'(time_diff), 32'd0);
        check("rst_syn", 32'(syn_current), 32'd0);
        rst_n = 1'b1;
        idle(8);
        drive(1'b1, 1'b0);
        check("pre_syn", 32'(syn_current), 32'd64);
        check("pre_noflag", 32'(update_w_flag), 32'd0);
        drive(1'b0, 1'b0);
        check("syn_off", 32'(syn_current), 32'd0);
        drive(1'b0, 1'b1);
        check_pair("ltp2", 80, 1, 2);
        drive(1'b0, 1'b0);
        check("flag_1cyc", 32'(update_w_flag), 32'd0);
        idle(16);
        drive(1'b0, 1'b1);
        check("lone_post", 32'(update_w_flag), 32'd0);
        idle(4);
        drive(1'b1, 1'b0);
        check_pair("ltd5", 72, 1, 5);
        check("ltd5_syn", 32'(syn_current), 32'd80);
        drive(1'b0, 1'b0);
        check("ltd5_off", 32'(update_w_flag), 32'd0);
        idle(16);
        for (int i = 0; i < 11; i++) begin
            ltp_pair(1);
            check_pair("ramp", 72 + 16 * (i + 1), 1, 1);
            idle(16);
        end
        ltp_pair(12);
        check_pair("ltp12", 250, 1, 12);
        idle(16);
        ltp_pair(1);
        check_pair("clip_hi", 255, 1, 1);
        idle(16);
        for (int i = 0; i < 15; i++) begin
            ltd_pair(1);
            check_pair("down", 255 - 16 * (i + 1), 1, 1);
            idle(16);
        end
        ltd_pair(5);
        check_pair("ltd_b2", 7, 1, 5);
        idle(16);
        ltd_pair(9);
        check_pair("ltd_b3", 3, 1, 9);
        idle(16);
        ltd_pair(13);
        check_pair("ltd13", 1, 1, 13);
        idle(16);
        ltd_pair(2);
        check_pair("clip_lo", 0, 1, 2);
        idle(16);
        ltp_pair(20);
        check_pair("expired", 0, 0, 0);
        idle(16);
        drive(1'b1, 1'b1);
        check_pair("simul", 0, 0, 0);
        idle(3);
        drive(1'b0, 1'b1);
        check_pair("after_sim", 8, 1, 4);
        idle(16);
        learn_en = 1'b0;
        ltp_pair(2);
        check_pair("frozen", 8, 1, 2);
        learn_en = 1'b1;
        idle(16);
        repeat (10) drive(1'b1, 1'b0);
        check("held_noflag", 32'(update_w_flag), 32'd0);
        idle(2);
        drive(1'b0, 1'b1);
        check_pair("held", 10, 1, 12);
        idle(16);
        drive(1'b1, 1'b0);
        check("mid_syn", 32'(syn_current), 32'd10);
        rst_n = 1'b0;
        #1;
        check("async_w", 32'(weight), 32'd64);
        drive(1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1);
        check_pair("post_rst", 64, 0, 0);
        check("post_rst_td", 32'(time_diff), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
